// File: rtl/bounce_counter_pkg.sv
// Shared types for the bounce counter: FSM state encoding, mode codes and
// the prescaler width helper.
package bounce_counter_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_UP    = 2'd2,
    ST_DOWN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_BOUNCE    = 2'b00,
    MODE_UP_WRAP   = 2'b01,
    MODE_DOWN_WRAP = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_t;

  // A divider of 1 still needs a 1-bit register to stay legal.
  function automatic int unsigned tick_cnt_width(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: asserts tick for one clk out of every DIV cycles,
// and on every cycle when DIV is 1.
module tick_gen
  import bounce_counter_pkg::*;
#(
  parameter int unsigned DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned     CW   = tick_cnt_width(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bounce_counter.sv
// Bounded up/down counter with bounce, wrap and hold modes, advanced by a
// prescaled tick. All outputs are registered; o_dbg_state exposes the FSM.
module bounce_counter
  import bounce_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             wrap,
  output logic             cfg_err,
  output state_t           o_dbg_state
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_wrap;
  logic             r_cfg_err;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_dir_nxt;
  logic             w_wrap_nxt;

  logic             w_tick;
  mode_t            w_mode;
  logic             w_frozen;
  logic             w_going_down;
  logic             w_in_range;
  logic             w_degenerate;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_mode       = mode_t'(mode);
  assign w_frozen     = (w_mode == MODE_HOLD) || r_cfg_err;
  assign w_in_range   = (r_count >= min_val) && (r_count <= max_val);
  assign w_degenerate = (min_val == max_val);

  // Wrap modes dictate direction immediately, even before the state catches up.
  always_comb begin
    w_going_down = (r_state == ST_DOWN);
    if (w_mode == MODE_DOWN_WRAP) begin
      w_going_down = 1'b1;
    end else if (w_mode == MODE_UP_WRAP) begin
      w_going_down = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_wrap_nxt  = 1'b0;

    case (r_state)
      ST_RESET: begin
        w_state_nxt = ST_UP;
      end
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = r_dir ? ST_DOWN : ST_UP;
        end
      end
      ST_UP, ST_DOWN: begin
        if (!en) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_frozen) begin
          if (w_mode == MODE_UP_WRAP) begin
            w_state_nxt = ST_UP;
            w_dir_nxt   = 1'b0;
          end else if (w_mode == MODE_DOWN_WRAP) begin
            w_state_nxt = ST_DOWN;
            w_dir_nxt   = 1'b1;
          end

          // A coincident load consumes the tick entirely.
          if (w_tick && !load) begin
            if (!w_in_range) begin
              w_count_nxt = (w_mode == MODE_DOWN_WRAP) ? max_val : min_val;
            end else if (w_degenerate) begin
              w_wrap_nxt = 1'b1;
            end else begin
              case (w_mode)
                MODE_BOUNCE: begin
                  if (!w_going_down) begin
                    if (r_count == max_val) begin
                      w_count_nxt = max_val - WIDTH'(1);
                      w_state_nxt = ST_DOWN;
                      w_dir_nxt   = 1'b1;
                      w_wrap_nxt  = 1'b1;
                    end else begin
                      w_count_nxt = r_count + WIDTH'(1);
                    end
                  end else begin
                    if (r_count == min_val) begin
                      w_count_nxt = min_val + WIDTH'(1);
                      w_state_nxt = ST_UP;
                      w_dir_nxt   = 1'b0;
                      w_wrap_nxt  = 1'b1;
                    end else begin
                      w_count_nxt = r_count - WIDTH'(1);
                    end
                  end
                end
                MODE_UP_WRAP: begin
                  if (r_count == max_val) begin
                    w_count_nxt = min_val;
                    w_wrap_nxt  = 1'b1;
                  end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                  end
                end
                MODE_DOWN_WRAP: begin
                  if (r_count == min_val) begin
                    w_count_nxt = max_val;
                    w_wrap_nxt  = 1'b1;
                  end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                  end
                end
                default: begin
                  w_count_nxt = r_count;
                end
              endcase
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
      end
    endcase

    if (load && (r_state != ST_RESET)) begin
      w_count_nxt = load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RESET;
      r_count   <= '0;
      r_dir     <= 1'b0;
      r_wrap    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_dir     <= w_dir_nxt;
      r_wrap    <= w_wrap_nxt;
      r_cfg_err <= (max_val < min_val);
    end
  end

  assign count       = r_count;
  assign dir         = r_dir;
  assign wrap        = r_wrap;
  assign cfg_err     = r_cfg_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bounce_counter.sv
// Directed bench for bounce_counter: one instance with DIV=1 for per-cycle
// behaviour and one with DIV=4 for prescaler timing, sharing all inputs.
module tb_bounce_counter;
  import bounce_counter_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] min_val = 4'd0;
  logic [W-1:0] max_val = 4'd15;
  logic [W-1:0] load_val = 4'd0;

  logic [W-1:0] c1, c4;
  logic         d1, d4, w1, w4, e1, e4;
  state_t       s1, s4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bounce_counter #(.WIDTH(W), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .min_val(min_val),
    .max_val(max_val), .load(load), .load_val(load_val), .count(c1),
    .dir(d1), .wrap(w1), .cfg_err(e1), .o_dbg_state(s1)
  );

  bounce_counter #(.WIDTH(W), .DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .min_val(min_val),
    .max_val(max_val), .load(load), .load_val(load_val), .count(c4),
    .dir(d4), .wrap(w4), .cfg_err(e4), .o_dbg_state(s4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int exp4;

    // Reset values
    step(2);
    check("rst_count", 32'(c1), 32'd0);
    check("rst_dir", 32'(d1), 32'd0);
    check("rst_wrap", 32'(w1), 32'd0);
    check("rst_cfg_err", 32'(e1), 32'd0);
    check("rst_state", 32'(s1), 32'(ST_RESET));
    check("rst_count4", 32'(c4), 32'd0);

    // Full bounce 0..15..0..1 with DIV=1
    rst = 1'b0;
    en  = 1'b1;
    step(1);
    check("bnc_first_state", 32'(s1), 32'(ST_UP));
    check("bnc_first_count", 32'(c1), 32'd0);
    for (int i = 1; i <= 15; i++) begin
      step(1);
      check("bnc_up_count", 32'(c1), 32'(i));
      check("bnc_up_wrap", 32'(w1), 32'd0);
      check("bnc_up_dir", 32'(d1), 32'd0);
    end
    for (int i = 14; i >= 0; i--) begin
      step(1);
      check("bnc_dn_count", 32'(c1), 32'(i));
      check("bnc_dn_wrap", 32'(w1), 32'(i == 14));
      check("bnc_dn_dir", 32'(d1), 32'd1);
    end
    step(1);
    check("bnc_rev_count", 32'(c1), 32'd1);
    check("bnc_rev_wrap", 32'(w1), 32'd1);
    check("bnc_rev_dir", 32'(d1), 32'd0);

    // Reset mid-count at 10 in DOWN
    load_val = 4'd10;
    load     = 1'b1;
    mode     = 2'b10;
    step(1);
    load = 1'b0;
    check("rstmid_pre_count", 32'(c1), 32'd10);
    check("rstmid_pre_state", 32'(s1), 32'(ST_DOWN));
    check("rstmid_pre_dir", 32'(d1), 32'd1);
    mode = 2'b00;
    rst  = 1'b1;
    step(1);
    check("rstmid_count", 32'(c1), 32'd0);
    check("rstmid_dir", 32'(d1), 32'd0);
    check("rstmid_state", 32'(s1), 32'(ST_RESET));
    check("rstmid_wrap", 32'(w1), 32'd0);
    rst = 1'b0;
    step(1);
    check("rstmid_up_state", 32'(s1), 32'(ST_UP));
    check("rstmid_up_count", 32'(c1), 32'd0);
    step(1);
    check("rstmid_tick_count", 32'(c1), 32'd1);

    // Pause at 7 in DOWN, resume
    load_val = 4'd7;
    load     = 1'b1;
    mode     = 2'b10;
    step(1);
    load = 1'b0;
    check("pause_pre_count", 32'(c1), 32'd7);
    check("pause_pre_state", 32'(s1), 32'(ST_DOWN));
    mode = 2'b00;
    en   = 1'b0;
    step(10);
    check("pause_state", 32'(s1), 32'(ST_IDLE));
    check("pause_count", 32'(c1), 32'd7);
    check("pause_dir", 32'(d1), 32'd1);
    en = 1'b1;
    step(1);
    check("resume_state", 32'(s1), 32'(ST_DOWN));
    check("resume_count0", 32'(c1), 32'd7);
    step(1);
    check("resume_count1", 32'(c1), 32'd6);
    step(1);
    check("resume_count2", 32'(c1), 32'd5);

    // Load outside bounds, then out-of-range recovery, then reversal at min
    min_val  = 4'd2;
    max_val  = 4'd9;
    load_val = 4'd12;
    load     = 1'b1;
    step(1);
    load = 1'b0;
    check("load_count", 32'(c1), 32'd12);
    check("load_wrap", 32'(w1), 32'd0);
    step(1);
    check("oor_count", 32'(c1), 32'd2);
    check("oor_wrap", 32'(w1), 32'd0);
    step(1);
    check("minrev_count", 32'(c1), 32'd3);
    check("minrev_wrap", 32'(w1), 32'd1);
    check("minrev_dir", 32'(d1), 32'd0);

    // Inverted bounds freeze the counter
    min_val = 4'd9;
    max_val = 4'd3;
    step(1);
    check("cfg_first_err", 32'(e1), 32'd1);
    check("cfg_first_count", 32'(c1), 32'd9);
    check("cfg_first_wrap", 32'(w1), 32'd0);
    step(3);
    check("cfg_frozen_count", 32'(c1), 32'd9);
    check("cfg_frozen_err", 32'(e1), 32'd1);
    max_val = 4'd12;
    step(1);
    check("cfg_clear_err", 32'(e1), 32'd0);
    check("cfg_clear_count", 32'(c1), 32'd9);
    step(1);
    check("cfg_resume_count", 32'(c1), 32'd10);

    // Prescaled up-wrap with DIV=4, min=3, max=5
    rst     = 1'b1;
    mode    = 2'b01;
    min_val = 4'd3;
    max_val = 4'd5;
    en      = 1'b1;
    step(2);
    rst = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      step(1);
      if (e < 4)       exp4 = 0;
      else if (e < 8)  exp4 = 3;
      else if (e < 12) exp4 = 4;
      else if (e < 16) exp4 = 5;
      else             exp4 = 3;
      check("div4_count", 32'(c4), 32'(exp4));
      check("div4_wrap", 32'(w4), 32'(e == 16));
    end
    check("div1_upwrap_count", 32'(c1), 32'd5);

    // Hold mode freezes, then degenerate bounds pulse wrap each tick
    mode = 2'b11;
    step(3);
    check("hold_count", 32'(c1), 32'd5);
    check("hold_wrap", 32'(w1), 32'd0);
    check("hold_state", 32'(s1), 32'(ST_UP));
    mode    = 2'b00;
    min_val = 4'd5;
    max_val = 4'd5;
    step(1);
    check("degen_count0", 32'(c1), 32'd5);
    check("degen_wrap0", 32'(w1), 32'd1);
    step(1);
    check("degen_count1", 32'(c1), 32'd5);
    check("degen_wrap1", 32'(w1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bounce_counter.md
BOUNCE_COUNTER -- requirements
Module: bounce_counter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 4, count width in bits; DIV, default 100000000, clk cycles per count tick (DIV>=1).
REQ-002 clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  run enable; low freezes counting.
REQ-005 mode  input  2  00 bounce, 01 up-wrap, 10 down-wrap, 11 hold.
REQ-006 min_val  input  WIDTH  lower bound, inclusive.
REQ-007 max_val  input  WIDTH  upper bound, inclusive.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value for load.
REQ-010 count  output  WIDTH  registered counter value.
REQ-011 dir  output  1  1 = counting down.
REQ-012 wrap  output  1  one-cycle pulse on bound reversal or wrap.
REQ-013 cfg_err  output  1  registered, high while max_val < min_val.

Function
REQ-014 All logic SHALL be on posedge clk only; there SHALL be no derived or divided clocks.
REQ-015 A tick strobe SHALL assert for one clk every DIV cycles; with DIV=1 it SHALL be high every cycle.
REQ-016 The FSM states SHALL be RESET, IDLE, UP, DOWN.
REQ-017 RESET SHALL move to UP on the first clk after rst deasserts.
REQ-018 In UP or DOWN, en=0 SHALL move to IDLE on the next clk; dir SHALL be retained.
REQ-019 In IDLE, en=1 SHALL move to UP if dir=0, else DOWN, on the next clk.
REQ-020 count SHALL change only on a tick while in UP or DOWN; wrap SHALL pulse in the same cycle as the count update.
REQ-021 In UP, a tick SHALL increment count by 1 modulo 2^WIDTH.
REQ-022 In DOWN, a tick SHALL decrement count by 1 modulo 2^WIDTH.
REQ-023 Bounce mode, UP at count==max_val: the tick SHALL set count=max_val-1, go to DOWN, set dir=1 and pulse wrap.
REQ-024 Bounce mode, DOWN at count==min_val: the tick SHALL set count=min_val+1, go to UP, set dir=0 and pulse wrap.
REQ-025 Up-wrap mode SHALL force UP and dir=0; at count==max_val a tick SHALL load min_val and pulse wrap.
REQ-026 Down-wrap mode SHALL force DOWN and dir=1; at count==min_val a tick SHALL load max_val and pulse wrap.
REQ-027 Hold mode, or cfg_err=1, SHALL freeze count and dir with no wrap; the state SHALL still follow en.
REQ-028 When min_val==max_val in any counting mode, a tick SHALL keep count at that value and pulse wrap.
REQ-029 When count is outside [min_val,max_val] at a tick, count SHALL load min_val in bounce and up-wrap modes, or max_val in down-wrap mode; wrap SHALL NOT pulse.
REQ-030 load=1 SHALL set count=load_val on the next clk in any non-RESET state, taking priority over a coincident tick; the tick is consumed.
REQ-031 Changes to min_val, max_val or mode SHALL take effect at the next tick; no latching is required.

Reset
REQ-032 rst SHALL set state=RESET, count=0, dir=0, wrap=0, cfg_err=0 and the tick prescaler to 0.
REQ-033 rst SHALL override load, en and tick in the same cycle.
REQ-034 rst asserted mid-count SHALL abandon the count immediately, with no completion of the current tick.

Structure
REQ-035 State encodings and mode codes SHALL be defined in a shared package, bounce_counter_pkg.
REQ-036 The prescaler SHALL be a sub-module, tick_gen (parameter DIV; ports clk, rst, tick), with a counter width of $clog2(DIV) bits, minimum 1.

Verification
REQ-037 WIDTH=4, DIV=1, min=0, max=15, bounce, en=1 after reset -> count 0,1..15,14..0,1 with wrap pulsing at the 15->14 and 0->1 steps.
REQ-038 DIV=4, up-wrap, min=3, max=5 -> count changes every 4th clk as 3,4,5,3 with wrap on the 5->3 step.
REQ-039 Bounce mode at count=7 in DOWN, en=0 for 10 clk then en=1 -> state IDLE, count held at 7, then resumes 6,5.
REQ-040 load=1 with load_val=12 on a tick cycle, min=2, max=9 -> count=12 next clk; following tick loads 2 with no wrap.
REQ-041 min=9, max=3 -> cfg_err=1 and count frozen; restore max=12 -> cfg_err=0 and counting resumes.
REQ-042 rst pulse at count=10 in DOWN -> next clk count=0, dir=0, state RESET; then UP and count=1 at the first tick.
